// File: rtl/bcd_stopwatch.sv
// Multi-digit BCD stopwatch / countdown timer with run/pause/done control.
// Optional lap capture register enabled by defining BCD_STOPWATCH_LAP_EN.
module bcd_stopwatch #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned TICK_DIV   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear,
  input  logic                    dir,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
`ifdef BCD_STOPWATCH_LAP_EN
  input  logic                    lap,
`endif
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    running,
  output logic                    done,
  output logic                    wrap,
  output logic [4*NUM_DIGITS-1:0] lap_digits
);

  localparam int unsigned W          = 4 * NUM_DIGITS;
  localparam logic [7:0]  PRESC_LAST = 8'(TICK_DIV - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   digits_q, digits_d;
  logic [7:0]     presc_q, presc_d;
  logic           dir_q, dir_d;
  logic           wrap_q, wrap_d;
  logic           running_q, done_q;
  logic [W-1:0]   inc_val, dec_val;
  logic           inc_carry;
  logic           step;
  logic           hit_zero;

  // Out-of-range nibbles (A-F) are treated as saturated: up wraps to 0 with carry.
  function automatic logic [W:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    logic [3:0]   d;
    r = v;
    c = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      d = v[4*i +: 4];
      if (c) begin
        if (d >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = d + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  // Down-count: an out-of-range nibble is pulled back to 9 and absorbs the borrow.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    logic [3:0]   d;
    r = v;
    b = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      d = v[4*i +: 4];
      if (b) begin
        if (d == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else if (d > 4'd9) begin
          r[4*i +: 4] = 4'd9;
          b = 1'b0;
        end else begin
          r[4*i +: 4] = d - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    {inc_carry, inc_val} = bcd_inc(digits_q);
    dec_val              = bcd_dec(digits_q);
  end

  assign step = tick && (presc_q == PRESC_LAST);

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    presc_d  = presc_q;
    dir_d    = dir_q;
    wrap_d   = 1'b0;
    hit_zero = 1'b0;
    if (clear) begin
      digits_d = '0;
      presc_d  = '0;
      state_d  = ST_IDLE;
    end else if (load && state_q != ST_RUN) begin
      digits_d = load_value;
      presc_d  = '0;
      state_d  = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            dir_d   = dir;
            state_d = (dir && digits_q == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (tick) begin
            presc_d = step ? '0 : presc_q + 8'd1;
          end
          if (step) begin
            if (!dir_q) begin
              digits_d = inc_val;
              wrap_d   = inc_carry;
            end else if (digits_q == '0) begin
              hit_zero = 1'b1;
            end else begin
              digits_d = dec_val;
              hit_zero = (dec_val == '0);
            end
          end
          // Reaching zero outranks a coincident stop; start masks stop.
          if (hit_zero)   state_d = ST_DONE;
          else if (start) state_d = ST_RUN;
          else if (stop)  state_d = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (start) begin
            dir_d   = dir;
            state_d = ST_RUN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      digits_q  <= '0;
      presc_q   <= '0;
      dir_q     <= 1'b0;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      presc_q   <= presc_d;
      dir_q     <= dir_d;
      wrap_q    <= wrap_d;
      running_q <= (state_d == ST_RUN);
      done_q    <= (state_d == ST_DONE);
    end
  end

  assign digits  = digits_q;
  assign running = running_q;
  assign done    = done_q;
  assign wrap    = wrap_q;

`ifdef BCD_STOPWATCH_LAP_EN
  logic [W-1:0] lap_q, lap_d;

  always_comb begin
    lap_d = lap_q;
    if (clear) begin
      lap_d = '0;
    end else if (lap && (state_q == ST_RUN || state_q == ST_PAUSE)) begin
      lap_d = digits_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lap_q <= '0;
    else     lap_q <= lap_d;
  end

  assign lap_digits = lap_q;
`else
  assign lap_digits = '0;
`endif

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed self-checking bench for bcd_stopwatch (TICK_DIV=1 and TICK_DIV=3 instances).
// Exercises the lap capture path only when BCD_STOPWATCH_LAP_EN is defined.
module tb_bcd_stopwatch;

  logic        clk = 1'b0;
  logic        rst, tick, start, stop, clear, dir, load;
  logic [15:0] load_value;
  logic [15:0] d1, l1, d3, l3;
  logic        r1, dn1, w1, r3, dn3, w3;
`ifdef BCD_STOPWATCH_LAP_EN
  logic        lap;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  bcd_stopwatch #(.NUM_DIGITS(4), .TICK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
    .clear(clear), .dir(dir), .load(load), .load_value(load_value),
`ifdef BCD_STOPWATCH_LAP_EN
    .lap(lap),
`endif
    .digits(d1), .running(r1), .done(dn1), .wrap(w1), .lap_digits(l1)
  );

  bcd_stopwatch #(.NUM_DIGITS(4), .TICK_DIV(3)) u_dut3 (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
    .clear(clear), .dir(dir), .load(load), .load_value(load_value),
`ifdef BCD_STOPWATCH_LAP_EN
    .lap(lap),
`endif
    .digits(d3), .running(r3), .done(dn3), .wrap(w3), .lap_digits(l3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given pulses held, then sample point 1 time unit after the edge.
  task automatic cycle_in(input logic c, input logic l, input logic s, input logic p, input logic t);
    clear = c; load = l; start = s; stop = p; tick = t;
    @(posedge clk);
    #1;
    clear = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    dir = 1'b0; load = 1'b0; load_value = 16'h0000;
`ifdef BCD_STOPWATCH_LAP_EN
    lap = 1'b0;
`endif
    #12;
    check("rst_digits", d1, 16'h0000);
    check("rst_running", r1, 0);
    check("rst_done", dn1, 0);
    check("rst_wrap", w1, 0);
    check("rst_lap", l1, 16'h0000);
    rst = 1'b0;

    // Up count to 1234 with both prescaler settings
    dir = 1'b0;
    cycle_in(1, 0, 0, 0, 0);
    cycle_in(0, 0, 1, 0, 0);
    ticks(1234);
    check("up_1234", d1, 16'h1234);
    check("up_running", r1, 1);
    check("up_done", dn1, 0);
    check("div3_0411", d3, 16'h0411);

    // Load ignored in RUN; rollover from 9998
    load_value = 16'h9998;
    cycle_in(0, 1, 0, 0, 0);
    check("load_in_run", d1, 16'h1234);
    cycle_in(0, 0, 0, 1, 0);
    check("stop_running", r1, 0);
    cycle_in(0, 1, 0, 0, 0);
    check("load_pause", d1, 16'h9998);
    cycle_in(0, 0, 1, 0, 0);
    ticks(1);
    check("roll_9999", d1, 16'h9999);
    check("roll_wrap_lo", w1, 0);
    ticks(1);
    check("roll_0000", d1, 16'h0000);
    check("roll_wrap_hi", w1, 1);
    check("roll_running", r1, 1);
    cycle_in(0, 0, 0, 0, 0);
    check("roll_wrap_1cyc", w1, 0);

    // Countdown from 0002
    cycle_in(1, 0, 0, 0, 0);
    load_value = 16'h0002;
    cycle_in(0, 1, 0, 0, 0);
    dir = 1'b1;
    cycle_in(0, 0, 1, 0, 0);
    ticks(1);
    check("dn1_0001", d1, 16'h0001);
    check("dn3_t1", d3, 16'h0002);
    ticks(1);
    check("dn1_0000", d1, 16'h0000);
    check("dn1_done", dn1, 1);
    check("dn1_not_run", r1, 0);
    check("dn3_t2", d3, 16'h0002);
    ticks(1);
    check("dn3_t3", d3, 16'h0001);
    check("dn3_run_t3", r3, 1);
    check("dn3_done_t3", dn3, 0);
    ticks(2);
    check("dn3_t5", d3, 16'h0001);
    ticks(1);
    check("dn3_t6", d3, 16'h0000);
    check("dn3_done_t6", dn3, 1);
    check("dn3_run_t6", r3, 0);
    ticks(3);
    check("dn3_hold", d3, 16'h0000);
    check("dn1_hold", d1, 16'h0000);
    dir = 1'b0;
    cycle_in(0, 0, 1, 0, 0);
    check("done_start_ign", dn3, 1);
    check("done_start_run", r3, 0);
    cycle_in(0, 0, 0, 1, 0);
    check("done_stop_ign", dn3, 1);

    // Start down at zero goes straight to DONE
    cycle_in(1, 0, 0, 0, 0);
    check("clear_done", dn1, 0);
    dir = 1'b1;
    cycle_in(0, 0, 1, 0, 0);
    check("zero_dn_done", dn1, 1);
    check("zero_dn_run", r1, 0);

    // Pause / resume
    cycle_in(1, 0, 0, 0, 0);
    dir = 1'b0;
    cycle_in(0, 0, 1, 0, 0);
    ticks(50);
    check("pr_0050", d1, 16'h0050);
    cycle_in(0, 0, 0, 1, 0);
    ticks(10);
    check("pr_hold", d1, 16'h0050);
    check("pr_paused", r1, 0);
    cycle_in(0, 0, 1, 0, 0);
    ticks(5);
    check("pr_0055", d1, 16'h0055);
    cycle_in(0, 0, 0, 1, 1);
    check("stop_tick_0056", d1, 16'h0056);
    check("stop_tick_pause", r1, 0);
    cycle_in(0, 0, 1, 0, 0);
    cycle_in(0, 0, 1, 1, 0);
    check("start_stop_run", r1, 1);

    // clear beats load and start
    load_value = 16'h1111;
    cycle_in(1, 1, 1, 0, 0);
    check("prio_digits", d1, 16'h0000);
    check("prio_running", r1, 0);
    check("prio_done", dn1, 0);

    // Non-BCD nibble recovery
    load_value = 16'h000A;
    cycle_in(0, 1, 0, 0, 0);
    dir = 1'b0;
    cycle_in(0, 0, 1, 0, 0);
    ticks(1);
    check("nbcd_up", d1, 16'h0010);
    cycle_in(0, 0, 0, 1, 0);
    cycle_in(0, 1, 0, 0, 0);
    dir = 1'b1;
    cycle_in(0, 0, 1, 0, 0);
    ticks(1);
    check("nbcd_dn", d1, 16'h0009);

    // Asynchronous reset mid-count
    ticks(3);
    check("pre_rst", d1, 16'h0006);
    #2 rst = 1'b1;
    #1;
    check("arst_digits", d1, 16'h0000);
    check("arst_running", r1, 0);
    check("arst_done", dn1, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;

`ifdef BCD_STOPWATCH_LAP_EN
    dir = 1'b0;
    cycle_in(1, 0, 0, 0, 0);
    cycle_in(0, 0, 1, 0, 0);
    ticks(42);
    lap = 1'b1;
    ticks(1);
    lap = 1'b0;
    check("lap_capture", l1, 16'h0042);
    check("lap_digits_on", d1, 16'h0043);
    ticks(5);
    check("lap_hold", l1, 16'h0042);
    check("lap_counting", d1, 16'h0048);
    cycle_in(1, 0, 0, 0, 0);
    check("lap_clear", l1, 16'h0000);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_stopwatch.md
Name: bcd_stopwatch

Overview:
- Parametrised multi-digit BCD stopwatch/countdown timer.
- Successor to the single-count binary timer. Counts directly in BCD, so no divide/modulo digit extraction is needed.
- Adds a run/pause/done state machine, up/down direction, preload and terminal-count detection.
- Sits between the slow-tick generator and the 7-segment display driver.

Parameters:
- NUM_DIGITS, 4, number of BCD digits. Legal range 1..8.
- TICK_DIV, 1, number of tick pulses per count step. Legal range 1..255. An internal prescaler counter is used when >1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- tick  input  1  single-cycle enable pulse from the slow clock divider
- start  input  1  pulse: begin or resume counting
- stop  input  1  pulse: pause counting
- clear  input  1  pulse: zero the count and return to IDLE
- dir  input  1  0 = count up, 1 = count down. Sampled only on start.
- load  input  1  pulse: preload the count from load_value. Honoured in IDLE and PAUSE only.
- load_value  input  4*NUM_DIGITS  BCD preload value; digit 0 is in bits [3:0]
- digits  output  4*NUM_DIGITS  current count in BCD; digit 0 = least significant digit, in bits [3:0]
- running  output  1  high while in RUN
- done  output  1  high while in DONE
- wrap  output  1  one-cycle pulse when an up-count rolls over from all-9s to 0
- lap_digits  output  4*NUM_DIGITS  captured lap value (see Optional Feature)

Behaviour:
- Reset values: digits=0, lap_digits=0, running=0, done=0, wrap=0, prescaler=0, latched direction=up, state=IDLE.
- States: IDLE, RUN, PAUSE, DONE.
- Input priority within one cycle: clear > load > start > stop.
- IDLE:
  - start → RUN; dir is latched internally at this point.
  - Exception: start with latched dir=down and digits==0 → DONE.
- RUN:
  - stop → PAUSE.
  - Each qualified step advances the count by one; see Step definition.
- PAUSE:
  - start → RUN; dir is re-latched.
  - Count and prescaler are held.
- DONE:
  - Count is held.
  - Only clear or load leave DONE; both go to IDLE. start and stop are ignored.
- clear (any state): digits=0, prescaler=0, state=IDLE, next cycle.
- load (IDLE, PAUSE or DONE): digits=load_value, prescaler=0, state=IDLE, next cycle. Ignored in RUN.
- Non-BCD load_value nibbles (A–F) are loaded as-is. On the first step the digit is forced back into range: up → 0 with carry; down → 9.
- Step definition:
  - In RUN, every tick increments the prescaler.
  - A step occurs on the tick where prescaler==TICK_DIV-1; the prescaler then returns to 0.
  - With TICK_DIV=1, every tick is a step.
- Latency: digits reflect a step on the clock edge after the qualifying tick cycle (1 cycle).
- Up count:
  - Ripple BCD increment: digit 9 → 0 carries into the next digit.
  - All-9s → all-0s, wrap pulses high for 1 cycle, state stays RUN.
- Down count:
  - Ripple BCD decrement: digit 0 → 9 borrows from the next digit.
  - When the step produces 0: state → DONE and done=1 on the same edge that digits becomes 0.
  - The count never decrements below 0.
- Simultaneous events:
  - stop in the same cycle as a qualifying tick: the step is applied and state → PAUSE.
  - start and stop together in RUN: start wins, so state stays RUN.
- Direction: the dir input is ignored except when start is accepted.
- Outputs: running and done are registered and decoded from state. No combinational path from inputs to outputs.
- Reset mid-operation: all state returns to reset values immediately (asynchronous).

Optional Feature:
- Macro: BCD_STOPWATCH_LAP_EN.
- With the macro defined:
  - Adds input lap (1-bit pulse).
  - lap in RUN or PAUSE captures digits into lap_digits on the next edge. The value captured is the pre-step value if a step occurs in the same cycle.
  - clear zeroes lap_digits.
- Without the macro:
  - No lap port.
  - lap_digits is tied to 0 and no capture register is synthesised.

Test Plan:
- Up count, TICK_DIV=1: clear, dir=0, start, 1234 ticks → digits=16'h1234, running=1, done=0.
- Rollover: load 16'h9998, start up, 2 ticks → digits 9999 then 0000; wrap high exactly 1 cycle on the second step; still RUN.
- Countdown, TICK_DIV=3: load 16'h0002, dir=1, start, 6 ticks → digits 0001 after tick 3, 0000 with done=1 after tick 6; further ticks leave 0000; start is ignored in DONE.
- Pause/resume: run up to 0050, stop, 10 ticks → digits hold 0050. start, 5 ticks → 0055. Also: stop coincident with a tick at 0055 → 0056 and PAUSE.
- Priority and reset: clear+load+start in the same cycle → digits=0, IDLE. load asserted in RUN is ignored. rst asserted mid-count → all outputs 0 immediately, without waiting for a clock edge.
- LAP (BCD_STOPWATCH_LAP_EN defined): lap at 0042 → lap_digits=0042 while digits keeps counting. clear → lap_digits=0.
